// File: rtl/overlay_text_generator_if.sv
// Host write port of the OSD character RAM.
// The host drives the master side; the overlay generator receives on the slave side.
interface overlay_text_generator_if;
   logic       wrEn;
   logic [7:0] wrAddr;   // {row[2:0], col[4:0]}
   logic [9:0] wrData;   // {colour[2:0] = R,G,B, charCode[6:0]}

   modport master (output wrEn, wrAddr, wrData);
   modport slave  (input  wrEn, wrAddr, wrData);
endinterface

// File: rtl/overlay_text_generator.sv
// Character-cell OSD overlay for PAL 576i.
// Locks to the incoming syncs, walks a COLS x ROWS character grid, fetches glyph rows
// through an external font ROM and emits 1-bit RGB.
// Black (000) means "nothing drawn", so the downstream key-on-black mixer shows video.
module overlay_text_generator #(
   parameter int H_START = 128,  // pixelEn ticks after the hsync edge where column 0 starts
   parameter int V_START = 40,   // line within the field where row 0 starts
   parameter int COLS    = 32,   // power of 2, max 32
   parameter int ROWS    = 8     // power of 2, max 8
) (
   input  logic                      clk,
   input  logic                      nReset,
   input  logic                      pixelEn,
   input  logic                      nHSync,
   input  logic                      nVSync,
   input  logic                      enable,
   overlay_text_generator_if.slave   host,
   output logic [9:0]                fontAddr,
   input  logic [7:0]                fontData,
   output logic                      redOut,
   output logic                      greenOut,
   output logic                      blueOut
);

   localparam int H_END = H_START + COLS * 16;  // each cell is 8 glyph bits x 2 ticks
   localparam int V_END = V_START + ROWS * 8;   // one glyph row per line

   logic       hs_q, vs_q;
   logic       h_fall, v_fall;
   logic [9:0] h_count;
   logic [8:0] v_count;

   logic [9:0] h_off;
   logic [8:0] v_off;
   logic       in_win;
   logic [7:0] rd_addr;

   logic [9:0] char_ram [256];

   // S1: registered RAM word plus the glyph coordinates that belong to it
   logic [9:0] rd_data;
   logic [2:0] s1_bit;
   logic [2:0] s1_font_row;
   logic       s1_active;
   // S2: selected glyph bit
   logic       s2_pix;
   logic [2:0] s2_colour;
   logic       s2_active;

   assign h_fall = hs_q & ~nHSync;
   assign v_fall = vs_q & ~nVSync;

   // Sync edge detection and saturating pixel/line counters; syncs win over pixelEn
   always_ff @(posedge clk or negedge nReset) begin
      if (!nReset) begin
         hs_q    <= 1'b1;
         vs_q    <= 1'b1;
         h_count <= '0;
         v_count <= '0;
      end else begin
         // NOTE: non-blocking assignments keep every register sampling pre-edge values,
         // which is what makes the edge detect and the pipeline stages line up.
         hs_q <= nHSync;
         vs_q <= nVSync;
         if (h_fall)
            h_count <= '0;
         else if (pixelEn && h_count != 10'h3FF)
            h_count <= h_count + 10'd1;
         if (v_fall)
            v_count <= '0;
         else if (h_fall && v_count != 9'h1FF)
            v_count <= v_count + 9'd1;
      end
   end

   // Window test and grid coordinates derived from the current counter values
   always_comb begin
      // NOTE: every output of this block is assigned on every pass, so no latch is inferred.
      h_off   = h_count - 10'(H_START);
      v_off   = v_count - 9'(V_START);
      in_win  = ({1'b0, h_count} >= 11'(H_START)) && ({1'b0, h_count} < 11'(H_END)) &&
                ({1'b0, v_count} >= 10'(V_START)) && ({1'b0, v_count} < 10'(V_END));
      rd_addr = {3'(v_off >> 3) & 3'(ROWS - 1), 5'(h_off >> 4) & 5'(COLS - 1)};
   end

   // Host write port of the character RAM
   always_ff @(posedge clk) begin
      // NOTE: the RAM array has no reset so it maps onto block RAM; software owns its contents.
      if (host.wrEn)
         char_ram[host.wrAddr] <= host.wrData;
   end

   // Three-stage pixel pipeline, advancing only on pixelEn
   always_ff @(posedge clk or negedge nReset) begin
      if (!nReset) begin
         rd_data     <= '0;
         s1_bit      <= '0;
         s1_font_row <= '0;
         s1_active   <= 1'b0;
         s2_pix      <= 1'b0;
         s2_colour   <= '0;
         s2_active   <= 1'b0;
         {redOut, greenOut, blueOut} <= 3'b000;
      end else if (pixelEn) begin
         // A write to the same address on this edge is not seen here: read-first.
         rd_data     <= char_ram[rd_addr];
         s1_bit      <= h_off[3:1];
         s1_font_row <= v_off[2:0];
         s1_active   <= in_win;

         s2_pix      <= fontData[3'd7 - s1_bit];
         s2_colour   <= rd_data[9:7];
         s2_active   <= s1_active;

         {redOut, greenOut, blueOut} <= (enable && s2_active && s2_pix) ? s2_colour : 3'b000;
      end
   end

   assign fontAddr = {rd_data[6:0], s1_font_row};

endmodule

// File: tb/tb_overlay_text_generator.sv
// Self-checking bench for overlay_text_generator.
// A behavioural model derives the expected RGB of every pixelEn tick straight from the
// window/cell arithmetic, a shadow copy of the character RAM and a font function.
module tb_overlay_text_generator;

   localparam int H0   = 128;
   localparam int V0   = 40;
   localparam int NCOL = 32;
   localparam int NROW = 8;

   logic       clk = 1'b0;
   logic       nReset;
   logic       pixelEn, nHSync, nVSync, enable;
   logic [9:0] fontAddr;
   logic [7:0] fontData;
   logic       redOut, greenOut, blueOut;

   overlay_text_generator_if bus ();

   overlay_text_generator #(.H_START(H0), .V_START(V0), .COLS(NCOL), .ROWS(NROW)) dut (
      .clk      (clk),
      .nReset   (nReset),
      .pixelEn  (pixelEn),
      .nHSync   (nHSync),
      .nVSync   (nVSync),
      .enable   (enable),
      .host     (bus.slave),
      .fontAddr (fontAddr),
      .fontData (fontData),
      .redOut   (redOut),
      .greenOut (greenOut),
      .blueOut  (blueOut)
   );

   always #5 clk = ~clk;

   int tests  = 0;
   int errors = 0;

   // model state
   bit         rom_fixed = 1'b1;
   logic [9:0] mram [256];
   int         mh, mv;
   bit         m_phs, m_pvs;
   logic [2:0] pq [$];
   logic [2:0] m_rgb;
   logic [2:0] line_log [0:1199];
   int         tick_no;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      tests++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
      end
   endtask

   // external font ROM: either a fixed 1000_0001 pattern or an address hash
   function automatic logic [7:0] font_fn(input logic [9:0] a);
      int v;
      if (rom_fixed) return 8'h81;
      v = int'(a);
      return 8'((v * 37) ^ (v >> 2) ^ 8'h5A);
   endfunction

   always @(posedge clk) fontData <= font_fn(fontAddr);

   function automatic bit in_window(input int h, input int v);
      return (h >= H0) && (h < H0 + NCOL * 16) && (v >= V0) && (v < V0 + NROW * 8);
   endfunction

   function automatic logic [2:0] ref_pixel(input int h, input int v);
      int col, bitn, row, fr;
      logic [9:0] d;
      logic [7:0] g;
      if (!in_window(h, v)) return 3'b000;
      col  = (h - H0) / 16;
      bitn = ((h - H0) / 2) % 8;
      row  = (v - V0) / 8;
      fr   = (v - V0) % 8;
      d    = mram[row * NCOL + col];
      g    = font_fn({d[6:0], 3'(fr)});
      return g[7 - bitn] ? d[9:7] : 3'b000;
   endfunction

   task automatic model_reset();
      mh = 0; mv = 0; m_phs = 1'b1; m_pvs = 1'b1; m_rgb = 3'b000;
      pq.delete();
      pq.push_back(3'b000);
      pq.push_back(3'b000);
   endtask

   // one clk cycle of stimulus, model update and output check
   task automatic step(input bit pe, input bit hs, input bit vs,
                       input bit we, input logic [7:0] wa, input logic [9:0] wd);
      bit hf, vf, fa_chk;
      logic [9:0] exp_fa, d;
      logic [2:0] tmp;
      @(negedge clk);
      pixelEn = pe; nHSync = hs; nVSync = vs;
      bus.wrEn = we; bus.wrAddr = wa; bus.wrData = wd;
      @(posedge clk);
      hf = m_phs && !hs;
      vf = m_pvs && !vs;
      fa_chk = 1'b0;
      exp_fa = '0;
      if (pe) begin
         pq.push_back(ref_pixel(mh, mv));          // RAM sampled before this edge's write
         if (in_window(mh, mv)) begin
            d      = mram[((mv - V0) / 8) * NCOL + (mh - H0) / 16];
            exp_fa = {d[6:0], 3'((mv - V0) % 8)};
            fa_chk = 1'b1;
         end
         tmp   = pq.pop_front();
         m_rgb = enable ? tmp : 3'b000;
      end
      if (vf)      mv = 0;
      else if (hf) mv = (mv < 511) ? mv + 1 : 511;
      if (hf)      mh = 0;
      else if (pe) mh = (mh < 1023) ? mh + 1 : 1023;
      if (we) mram[wa] = wd;
      m_phs = hs; m_pvs = vs;
      #1;
      check("rgb", {29'd0, redOut, greenOut, blueOut}, {29'd0, m_rgb});
      if (fa_chk) check("font_addr", {22'd0, fontAddr}, {22'd0, exp_fa});
   endtask

   task automatic idle(input bit rnd);
      bit we;
      we = rnd && ($urandom_range(0, 3) == 0);
      step(1'b0, 1'b1, 1'b1, we, 8'($urandom), 10'($urandom));
   endtask

   task automatic pixel(input bit rnd, input bit wf, input logic [7:0] wa, input logic [9:0] wd);
      bit we;
      logic [7:0] a;
      logic [9:0] d;
      we = wf; a = wa; d = wd;
      if (!wf && rnd && $urandom_range(0, 7) == 0) begin
         we = 1'b1; a = 8'($urandom); d = 10'($urandom);
      end
      if (rnd && $urandom_range(0, 49) == 0) enable = ~enable;
      step(1'b1, 1'b1, 1'b1, we, a, d);
      tick_no++;
      if (tick_no < 1200) line_log[tick_no] = {redOut, greenOut, blueOut};
      repeat ($urandom_range(1, 2)) idle(rnd);
   endtask

   task automatic hsync();
      step(1'b0, 1'b0, 1'b1, 1'b0, 8'd0, 10'd0);
      step(1'b0, 1'b1, 1'b1, 1'b0, 8'd0, 10'd0);
      tick_no = 0;
   endtask

   task automatic run_line(input int n, input bit rnd);
      hsync();
      for (int i = 0; i < n; i++) pixel(rnd, 1'b0, 8'd0, 10'd0);
   endtask

   task automatic field_start(input bit together);
      idle(1'b0);
      if (together) step(1'b1, 1'b0, 1'b0, 1'b0, 8'd0, 10'd0);  // vsync+hsync+pixelEn on one clk
      else          step(1'b0, 1'b1, 1'b0, 1'b0, 8'd0, 10'd0);
      step(1'b0, 1'b1, 1'b1, 1'b0, 8'd0, 10'd0);
   endtask

   task automatic do_reset();
      #2;
      nReset = 1'b0;
      #1;
      check("rst_rgb", {29'd0, redOut, greenOut, blueOut}, 32'd0);
      check("rst_font_addr", {22'd0, fontAddr}, 32'd0);
      model_reset();
      pixelEn = 1'b0; nHSync = 1'b1; nVSync = 1'b1; bus.wrEn = 1'b0;
      repeat (2) @(negedge clk);
      nReset = 1'b1;
   endtask

   initial begin
      nReset = 1'b1; pixelEn = 1'b0; nHSync = 1'b1; nVSync = 1'b1; enable = 1'b1;
      bus.wrEn = 1'b0; bus.wrAddr = '0; bus.wrData = '0;
      tick_no = 0;
      model_reset();
      #7;
      do_reset();

      // fill the character RAM, then place an 'A' in red at row 0 col 0
      for (int a = 0; a < 256; a++) step(1'b0, 1'b1, 1'b1, 1'b1, 8'(a), 10'($urandom));
      step(1'b0, 1'b1, 1'b1, 1'b1, 8'd0, {3'b100, 7'h41});

      // field A: fixed 1000_0001 glyph rows, separate vsync
      rom_fixed = 1'b1;
      field_start(1'b0);
      for (int l = 1; l < V0; l++) run_line(5, 1'b0);

      // line V0: glyph bits 0 and 7 of col 0 appear 3 ticks after hCount 128
      run_line(700, 1'b0);
      check("glyph_t130", {29'd0, line_log[130]}, 32'd0);
      check("glyph_t131", {29'd0, line_log[131]}, 32'b100);
      check("glyph_t132", {29'd0, line_log[132]}, 32'b100);
      check("glyph_t133", {29'd0, line_log[133]}, 32'd0);
      check("glyph_t144", {29'd0, line_log[144]}, 32'd0);
      check("glyph_t145", {29'd0, line_log[145]}, 32'b100);
      check("glyph_t146", {29'd0, line_log[146]}, 32'b100);

      // line V0+1: drop enable for tick 145 only, restore for 146
      hsync();
      for (int t = 1; t <= 700; t++) begin
         if (t == 145) enable = 1'b0;
         if (t == 146) enable = 1'b1;
         pixel(1'b0, 1'b0, 8'd0, 10'd0);
      end
      check("en_off", {29'd0, line_log[145]}, 32'd0);
      check("en_on",  {29'd0, line_log[146]}, 32'b100);

      // line V0+2: rewrite col 0 on the very tick S1 reads it (hCount 128)
      hsync();
      for (int t = 1; t <= 700; t++)
         pixel(1'b0, (t == 129), 8'd0, {3'b010, 7'h41});
      check("collide_old", {29'd0, line_log[131]}, 32'b100);
      run_line(700, 1'b0);
      check("collide_new", {29'd0, line_log[131]}, 32'b010);

      // hCount saturation: 1100 ticks without hsync must not wrap back into the window
      run_line(1100, 1'b0);
      check("sat_end", {29'd0, line_log[1100]}, 32'd0);

      // field B: hashed font, random writes/enable, vsync+hsync+pixelEn together
      rom_fixed = 1'b0;
      field_start(1'b1);
      for (int l = 1; l <= 110; l++) begin
         bit full;
         full = (l >= V0) && (l <= 105) &&
                (l == V0 || l == 103 || l == 104 || $urandom_range(0, 6) == 0);
         run_line(full ? 630 + $urandom_range(0, 60) : 5, 1'b1);
      end
      enable = 1'b1;

      // mid-line reset inside the window, then nothing may be drawn on the next lines
      field_start(1'b0);
      for (int l = 1; l < V0; l++) run_line(5, 1'b0);
      run_line(300, 1'b0);
      do_reset();
      run_line(700, 1'b0);
      run_line(700, 1'b0);

      $display("[TB] %0d tests run, %0d failed", tests, errors);
      $finish;
   end

   // global watchdog
   initial begin
      #3000000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

endmodule

// File: doc/overlay_text_generator.md
Name: overlay_text_generator

Overview:
- Character-cell on-screen-display source that produces the 1-bit RGB overlay stream consumed by the video mixer's key-on-black input.
- Locks to the incoming PAL 576i syncs and counts pixels and lines.
- Reads character codes from an internal character RAM that the host writes, looks up glyph rows through an external font ROM port, and serialises the glyph bits.
- Emits black (000) wherever nothing is drawn, so the mixer passes the background video through.

Parameters:
H_START, 128, pixelEn count after the nHSync falling edge at which column 0 begins
V_START, 40, line count within the field at which row 0 begins
COLS, 32, character columns (power of 2, max 32)
ROWS, 8, character rows (power of 2, max 8)

Ports:
clk  input  1  system clock
nReset  input  1  asynchronous active-low reset
pixelEn  input  1  pixel strobe, one clk wide, asserted at most once every 2 clk
nHSync  input  1  active-low line sync, synchronous to clk
nVSync  input  1  active-low field sync, synchronous to clk
enable  input  1  overlay enable
wrEn  input  1  character RAM write strobe
wrAddr  input  8  {row[2:0], col[4:0]}
wrData  input  10  {colour[2:0] = R,G,B, charCode[6:0]}
fontAddr  output  10  {charCode[6:0], fontRow[2:0]}
fontData  input  8  glyph row from the external ROM, valid 1 clk after fontAddr; MSB is the leftmost pixel
redOut  output  1  overlay red
greenOut  output  1  overlay green
blueOut  output  1  overlay blue

Behaviour:
Reset:
- redOut, greenOut, blueOut, fontAddr, hCount, vCount and all pipeline valid flags go to 0 immediately on nReset low.
- Character RAM contents are not reset.

Sync:
- nHSync and nVSync are each registered once for edge detection.
- nHSync falling edge: hCount := 0 and vCount := vCount+1.
- nVSync falling edge: vCount := 0. A simultaneous nHSync edge is overridden, so vCount is 0.
- A sync edge takes priority over a coincident pixelEn.
- Otherwise hCount increments on pixelEn.
- hCount (10 b) saturates at 1023; vCount (9 b) saturates at 511.

Active region:
- Active when H_START <= hCount < H_START+COLS*16 and V_START <= vCount < V_START+ROWS*8.
- Each glyph bit spans 2 pixelEn ticks, so one cell is 16 ticks.
- col = (hCount-H_START)>>4; bit = ((hCount-H_START)>>1)&7.
- row = (vCount-V_START)>>3; fontRow = (vCount-V_START)&7.
- Each field shows one glyph row per line.

Pipeline (advances only on pixelEn):
- S1: registered RAM read of {row,col}; latch colour, charCode, bit, active; drive fontAddr = {charCode, fontRow}.
- S2: latch fontData[7-bit], colour, active.
- S3: outputs := (enable && active && pixel) ? colour : 000.
- Output latency is 3 pixelEn ticks from the hCount value.
- enable is sampled at S3 only, so disabling blanks from the next pixelEn.
- Outputs hold between pixelEn strobes.

Character RAM:
- 256x10, with a write port independent of the read port.
- A write lands on the clk edge where wrEn is high.
- A read of the same address on the same edge returns the old data (read-first).
- wrAddr with col >= COLS or row >= ROWS is stored but never displayed.
- colour 000 renders transparent; this is by design.

Reset mid-line:
- Counters restart from 0, so nothing is drawn until hCount and vCount re-enter the window after the next syncs.

Test Plan:
- Reset: nReset low mid-line -> RGB = 000, fontAddr = 0 within the same clk; after release, RGB stays 000 until the window is reached.
- Glyph render: write addr 0 = {3'b100, 7'h41}; ROM returns 8'b1000_0001 for every row; drive V_START lines -> at line V_START, red = 1 for pixelEn ticks 131-132 (H_START+3, accounting for latency) and again for ticks 145-146, 000 elsewhere.
- Sync priority: nVSync and nHSync falling on the same clk as pixelEn -> vCount = 0, hCount = 0.
- Saturation: 1100 pixelEn without an hsync -> hCount stays 1023, RGB = 000, no wrap-around drawing.
- Read-first collision: write col 0 while S1 reads col 0 -> that character shows old data; the next line shows new data.
- Enable gating: clear enable mid-glyph -> RGB = 000 from the next pixelEn; set it again -> the glyph resumes aligned to hCount.
